// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arb_pkg;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned BMASK_W         = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-memory requests onto one single-port memory bus.
// Data side wins ties; grants are non-preemptive and abort on timeout.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               if_req_i,
  input  logic [ADDR_W-1:0]  if_addr_i,
  output logic [DATA_W-1:0]  if_rdata_o,
  output logic               if_ack_o,
  input  logic               dm_rden_i,
  input  logic               dm_wren_i,
  input  logic [ADDR_W-1:0]  dm_addr_i,
  input  logic [DATA_W-1:0]  dm_wdata_i,
  input  logic [BMASK_W-1:0] dm_bmask_i,
  output logic [DATA_W-1:0]  dm_rdata_o,
  output logic               dm_ack_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  output logic [BMASK_W-1:0] mem_bmask_o,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  input  logic               mem_ack_i,
  output logic               stall_if_o,
  output logic               stall_mem_o,
  output logic               err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BMASK_W-1:0] bmask_q, bmask_d;

  logic dm_any;
  logic busy;
  logic timeout;

  assign dm_any  = dm_rden_i | dm_wren_i;
  assign busy    = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign timeout = busy && (cnt_q == CNT_W'(TIMEOUT_CYC));

  // Completion pulses: gated by reset and timeout, suppressed if the owner dropped its request
  assign if_ack_o   = rst_ni & (state_q == BUSY_IF) & mem_ack_i & ~timeout & if_req_i;
  assign dm_ack_o   = rst_ni & (state_q == BUSY_DM) & mem_ack_i & ~timeout & dm_any;
  assign if_rdata_o = if_ack_o ? mem_rdata_i : '0;
  assign dm_rdata_o = dm_ack_o ? mem_rdata_i : '0;
  assign err_o      = rst_ni & timeout;

  assign stall_if_o  = if_req_i & ~if_ack_o;
  assign stall_mem_o = dm_any & ~dm_ack_o;

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_bmask_o = bmask_q;

  // Next-state, request-bus and timeout-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    case (state_q)
      IDLE: begin
        if (dm_any) begin
          state_d = BUSY_DM;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = dm_wren_i;
          addr_d  = dm_addr_i;
          wdata_d = dm_wdata_i;
          bmask_d = dm_bmask_i;
        end else if (if_req_i) begin
          state_d = BUSY_IF;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          wdata_d = '0;
          bmask_d = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (timeout || mem_ack_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          bmask_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        bmask_d = '0;
      end
    endcase
  end

  // All state on one synchronous active-low reset process
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_rden_i;
  logic        dm_wren_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_bmask_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_bmask_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.TIMEOUT_CYC(255)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .dm_rden_i   (dm_rden_i),
    .dm_wren_i   (dm_wren_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_bmask_i  (dm_bmask_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ack_o    (dm_ack_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_bmask_o (mem_bmask_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .stall_if_o  (stall_if_o),
    .stall_mem_o (stall_mem_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Hard stop if the sequence somehow never completes
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; inputs are driven here
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_rden_i   = 1'b0;
    dm_wren_i   = 1'b0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    dm_bmask_i  = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    if_req_i  = 1'b1;
    dm_wren_i = 1'b1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    cyc();
    cyc();
    #1;
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
    n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", mem_we_o); end
    n_tests++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_bmask_o !== 4'h0) begin
      n_fail++; $display("FAIL reset_bus got addr %h wdata %h bmask %h exp 0", mem_addr_o, mem_wdata_o, mem_bmask_o); end
    n_tests++; if (if_ack_o !== 1'b0 || dm_ack_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_acks got if %b dm %b err %b exp 0", if_ack_o, dm_ack_o, err_o); end
    n_tests++; if (if_rdata_o !== 32'h0 || dm_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got if %h dm %h exp 0", if_rdata_o, dm_rdata_o); end
    idle_inputs();
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_fetch();
    cyc();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    #1;
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL fetch_req_early got %b exp 0", mem_req_o); end
    n_tests++; if (stall_if_o !== 1'b1) begin n_fail++; $display("FAIL fetch_stall got %b exp 1", stall_if_o); end
    cyc(); #1;
    n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL fetch_grant got req %b addr %h exp 1 00000100", mem_req_o, mem_addr_o); end
    n_tests++; if (mem_we_o !== 1'b0 || mem_wdata_o !== 32'h0 || mem_bmask_o !== 4'h0) begin
      n_fail++; $display("FAIL fetch_bus got we %b wdata %h bmask %h exp 0", mem_we_o, mem_wdata_o, mem_bmask_o); end
    cyc(); #1;
    n_tests++; if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL fetch_noack got ack %b rdata %h exp 0", if_ack_o, if_rdata_o); end
    cyc();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0050_0093;
    #1;
    n_tests++; if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h0050_0093) begin
      n_fail++; $display("FAIL fetch_ack got ack %b rdata %h exp 1 00500093", if_ack_o, if_rdata_o); end
    n_tests++; if (stall_if_o !== 1'b0 || dm_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL fetch_ack_side got stall %b dm_ack %b exp 0 0", stall_if_o, dm_ack_o); end
    cyc();
    idle_inputs();
    #1;
    n_tests++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL fetch_done got req %b addr %h exp 0", mem_req_o, mem_addr_o); end
  endtask

  task automatic test_back_to_back();
    cyc();
    if_req_i = 1'b1; if_addr_i = 32'h400;
    dm_wren_i = 1'b1; dm_addr_i = 32'h2000; dm_wdata_i = 32'hDEAD_BEEF; dm_bmask_i = 4'hF;
    #1;
    n_tests++; if (stall_if_o !== 1'b1 || stall_mem_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stall_req got if %b mem %b exp 1 1", stall_if_o, stall_mem_o); end
    cyc(); #1;
    n_tests++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h2000) begin
      n_fail++; $display("FAIL b2b_store_grant got req %b we %b addr %h exp 1 1 00002000", mem_req_o, mem_we_o, mem_addr_o); end
    n_tests++; if (mem_wdata_o !== 32'hDEAD_BEEF || mem_bmask_o !== 4'hF) begin
      n_fail++; $display("FAIL b2b_store_data got wdata %h bmask %h exp deadbeef f", mem_wdata_o, mem_bmask_o); end
    cyc();
    mem_ack_i = 1'b1;
    #1;
    n_tests++; if (dm_ack_o !== 1'b1 || if_ack_o !== 1'b0 || stall_mem_o !== 1'b0 || stall_if_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_store_ack got dm %b if %b stall_mem %b stall_if %b exp 1 0 0 1",
                         dm_ack_o, if_ack_o, stall_mem_o, stall_if_o); end
    cyc();
    mem_ack_i = 1'b0; dm_wren_i = 1'b0;
    #1;
    n_tests++; if (mem_req_o !== 1'b0 || stall_if_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_bubble got req %b stall_if %b exp 0 1", mem_req_o, stall_if_o); end
    cyc(); #1;
    n_tests++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h400 ||
                   mem_wdata_o !== 32'h0 || mem_bmask_o !== 4'h0 || stall_if_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_fetch_grant got req %b we %b addr %h wdata %h bmask %h stall %b exp 1 0 00000400 0 0 1",
                         mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_bmask_o, stall_if_o); end
    cyc();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1;
    n_tests++; if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h1234_5678 || dm_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL b2b_fetch_ack got ack %b rdata %h dm_rdata %h exp 1 12345678 0", if_ack_o, if_rdata_o, dm_rdata_o); end
    cyc();
    idle_inputs();
    #1;
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done got req %b exp 0", mem_req_o); end
  endtask

  task automatic test_load_rmw();
    // Load: read grant keeps we low and returns data on dm side
    cyc();
    dm_rden_i = 1'b1; dm_addr_i = 32'h3004; dm_wdata_i = 32'h11; dm_bmask_i = 4'h3;
    cyc(); #1;
    n_tests++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h3004) begin
      n_fail++; $display("FAIL load_grant got req %b we %b addr %h exp 1 0 00003004", mem_req_o, mem_we_o, mem_addr_o); end
    cyc();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5_0F0F;
    #1;
    n_tests++; if (dm_ack_o !== 1'b1 || dm_rdata_o !== 32'hA5A5_0F0F) begin
      n_fail++; $display("FAIL load_ack got ack %b rdata %h exp 1 a5a50f0f", dm_ack_o, dm_rdata_o); end
    cyc();
    mem_ack_i = 1'b0;
    dm_wren_i = 1'b1;
    #1;
    // Bubble, then rden&wren is granted as a store
    cyc(); #1;
    n_tests++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin
      n_fail++; $display("FAIL rmw_store got req %b we %b exp 1 1", mem_req_o, mem_we_o); end
    cyc();
    mem_ack_i = 1'b1;
    cyc();
    idle_inputs();
    #1;
    n_tests++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
      n_fail++; $display("FAIL rmw_done got req %b we %b exp 0 0", mem_req_o, mem_we_o); end
  endtask

  task automatic test_flush();
    cyc();
    if_req_i = 1'b1; if_addr_i = 32'h200;
    cyc(); #1;
    n_tests++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL flush_grant got req %b exp 1", mem_req_o); end
    cyc();
    if_req_i = 1'b0;
    #1;
    n_tests++; if (stall_if_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL flush_hold got stall %b req %b addr %h exp 0 1 00000200", stall_if_o, mem_req_o, mem_addr_o); end
    cyc();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA_5555;
    #1;
    n_tests++; if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL flush_ack got ack %b rdata %h exp 0 0", if_ack_o, if_rdata_o); end
    cyc();
    idle_inputs();
    #1;
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle got req %b exp 0", mem_req_o); end
  endtask

  task automatic test_idle_ack();
    cyc();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    n_tests++; if (if_ack_o !== 1'b0 || dm_ack_o !== 1'b0 || if_rdata_o !== 32'h0 || dm_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL idle_ack got if %b dm %b if_rdata %h dm_rdata %h exp 0", if_ack_o, dm_ack_o, if_rdata_o, dm_rdata_o); end
    cyc();
    idle_inputs();
    #1;
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_ack_state got req %b exp 0", mem_req_o); end
  endtask

  task automatic test_timeout();
    int err_cnt  = 0;
    int err_at   = 0;
    int ack_seen = 0;
    int req_drop = 0;
    cyc();
    dm_rden_i = 1'b1; dm_addr_i = 32'h3000;
    for (int k = 1; k <= 256; k++) begin
      cyc(); #1;
      if (err_o === 1'b1) begin err_cnt++; err_at = k; end
      if (dm_ack_o !== 1'b0) ack_seen++;
      if (mem_req_o !== 1'b1) req_drop++;
    end
    n_tests++; if (err_cnt != 1 || err_at != 256) begin
      n_fail++; $display("FAIL timeout_err got pulses %0d at busy cycle %0d exp 1 at 256", err_cnt, err_at); end
    n_tests++; if (ack_seen != 0 || req_drop != 0) begin
      n_fail++; $display("FAIL timeout_busy got acks %0d req_drops %0d exp 0 0", ack_seen, req_drop); end
    cyc();
    dm_rden_i = 1'b0;
    #1;
    n_tests++; if (mem_req_o !== 1'b0 || err_o !== 1'b0 || dm_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_after got req %b err %b ack %b exp 0 0 0", mem_req_o, err_o, dm_ack_o); end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    cyc();
    dm_wren_i = 1'b1; dm_addr_i = 32'h5000; dm_wdata_i = 32'h1; dm_bmask_i = 4'h1;
    cyc(); #1;
    n_tests++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_grant got req %b we %b exp 1 1", mem_req_o, mem_we_o); end
    cyc();
    rst_ni = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    #1;
    n_tests++; if (dm_ack_o !== 1'b0 || dm_rdata_o !== 32'h0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_inreset got ack %b rdata %h err %b exp 0 0 0", dm_ack_o, dm_rdata_o, err_o); end
    cyc();
    rst_ni = 1'b1; dm_wren_i = 1'b0; mem_ack_i = 1'b1;
    #1;
    n_tests++; if (dm_ack_o !== 1'b0 || if_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_stale got dm %b if %b req %b exp 0 0 0", dm_ack_o, if_ack_o, mem_req_o); end
    cyc();
    idle_inputs();
    #1;
    n_tests++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h0 ||
                   mem_wdata_o !== 32'h0 || mem_bmask_o !== 4'h0) begin
      n_fail++; $display("FAIL rstmid_idle got req %b we %b addr %h wdata %h bmask %h exp 0",
                         mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_bmask_o); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_load_rmw();
    test_flush();
    test_idle_ack();
    test_timeout();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
